// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode constants and the fetch
// stage state encoding. ST_HALT exists only when FETCH_MISALIGN_EN is defined.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1
`ifdef FETCH_MISALIGN_EN
    ,
    ST_HALT  = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x WIDTH synchronous FIFO with push, pop, flush and
// an occupancy count. Head entry is always visible on rdata. DEPTH must be a
// power of two so the pointers wrap naturally. Unaffected by FETCH_MISALIGN_EN.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so push and pop on a full buffer both occur.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; data needs no reset because count gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches 32-bit words over a req/valid
// handshake, buffers {instr, pc} in fetch_fifo and hands them to decode.
// Optional feature FETCH_MISALIGN_EN adds the misalign output and HALT state
// for redirect targets with nonzero low bits; without it those bits are cleared.
//
// Handshakes:
//   imem: imem_req/imem_addr are registered and held until imem_valid is seen
//         high in a cycle where imem_req is high; that cycle completes the fetch.
//   out:  a transfer happens on a rising edge where out_valid && out_ready;
//         out_* are stable while out_valid is high and the entry is not taken.
import cpu_pkg::*;

module instr_fetch #(
  parameter int                PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [6:0]          out_opcode,
  output logic [PC_WIDTH-1:0] out_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_WIDTH + PC_WIDTH;

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pending_pc;
  logic [PC_WIDTH-1:0] tgt_pc;
  logic [PC_WIDTH-1:0] drain_pc;
  logic [CW-1:0]       count;
  logic [CW-1:0]       occ_next;
  logic [EW-1:0]       head;
  logic                pop;
  logic                outstanding;
  logic                push;
`ifdef FETCH_MISALIGN_EN
  logic                tgt_bad;
  logic                pending_bad;
  logic                drain_bad;
`endif

  // Redirect target legality: with the feature, low bits flag a misaligned target.
`ifdef FETCH_MISALIGN_EN
  assign tgt_pc    = redirect_pc;
  assign tgt_bad   = |redirect_pc[1:0];
  assign drain_bad = redirect ? tgt_bad : pending_bad;
`else
  assign tgt_pc    = redirect_pc & ~PC_WIDTH'(3);
`endif

  // A redirect on the very cycle the old response lands takes priority over the pending target.
  assign drain_pc    = redirect ? tgt_pc : pending_pc;
  assign pop         = out_valid && out_ready;
  assign outstanding = imem_req && !imem_valid;
  assign push        = imem_req && imem_valid && (state == ST_RUN) && !redirect;
  assign occ_next    = redirect ? '0 : (count + CW'(push) - CW'(pop));

  assign imem_addr  = fetch_pc;
  assign out_valid  = (count != '0);
  assign out_instr  = head[EW-1:PC_WIDTH];
  assign out_pc     = head[PC_WIDTH-1:0];
  assign out_opcode = out_instr[6:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rdata, fetch_pc}),
    .rdata (head),
    .count (count)
  );

  // Fetch FSM: sequences requests, redirects and draining of a stale in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      imem_req   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      pending_bad <= 1'b0;
      misalign    <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_EN
      if (redirect) misalign <= tgt_bad;
`endif
      case (state)
        ST_RUN: begin
          if (redirect) begin
            if (outstanding) begin
              // Old request must complete first; its address stays on the bus.
              pending_pc <= tgt_pc;
`ifdef FETCH_MISALIGN_EN
              pending_bad <= tgt_bad;
`endif
              state    <= ST_DRAIN;
              imem_req <= 1'b1;
            end
`ifdef FETCH_MISALIGN_EN
            else if (tgt_bad) begin
              state    <= ST_HALT;
              imem_req <= 1'b0;
            end
`endif
            else begin
              fetch_pc <= tgt_pc;
              imem_req <= 1'b1;
            end
          end else begin
            if (push) fetch_pc <= fetch_pc + PC_WIDTH'(4);
            imem_req <= (occ_next < CW'(DEPTH));
          end
        end
        ST_DRAIN: begin
          imem_req <= 1'b1;
          if (redirect) begin
            pending_pc <= tgt_pc;
`ifdef FETCH_MISALIGN_EN
            pending_bad <= tgt_bad;
`endif
          end
          if (imem_valid) begin
`ifdef FETCH_MISALIGN_EN
            if (drain_bad) begin
              state    <= ST_HALT;
              imem_req <= 1'b0;
            end else
`endif
            begin
              fetch_pc <= drain_pc;
              state    <= ST_RUN;
              imem_req <= 1'b1;
            end
          end
        end
`ifdef FETCH_MISALIGN_EN
        ST_HALT: begin
          imem_req <= 1'b0;
          if (redirect && !tgt_bad) begin
            fetch_pc <= tgt_pc;
            state    <= ST_RUN;
            imem_req <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= ST_RUN;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
